// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: default widths, address/instruction words and FSM states.
package cpu_pkg;

  localparam int CPU_ADDR_W = 6;
  localparam int CPU_DATA_W = 32;

  typedef logic [CPU_ADDR_W-1:0] addr_t;
  typedef logic [CPU_DATA_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect beats sequential advance; the end address either
// wraps to zero or holds, leaving the halt decision to the FSM.
module fetch_pc_reg #(
  parameter int ADDR_W    = 6,
  parameter int LAST_ADDR = 63,
  parameter int WRAP_EN   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;

  // Select the next pc; the increment rolls over modulo 2^ADDR_W.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect) begin
      pc_next_s = redirect_addr;
    end else if (advance) begin
      if (pc_r == ADDR_W'(LAST_ADDR)) begin
        if (WRAP_EN != 0) begin
          pc_next_s = {ADDR_W{1'b0}};
        end else begin
          pc_next_s = pc_r;
        end
      end else begin
        pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // pc register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= {ADDR_W{1'b0}};
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives imem_addr from pc, captures read data into a single
// valid/ready slot, counts accepted handshakes, and handles halt/wrap/redirect.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int DATA_W    = CPU_DATA_W,
  parameter int LAST_ADDR = 63,
  parameter int WRAP_EN   = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      state_r;
  fetch_state_t      next_state_s;
  logic [ADDR_W-1:0] pc_s;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic              instr_valid_r;
  logic              halted_r;
  logic [CNT_W-1:0]  fetch_count_r;
  logic              redirect_s;
  logic              capture_s;
  logic              handshake_s;
  logic              at_last_s;

  // Redirect is ignored in IDLE; capture needs a free slot and no redirect.
  assign redirect_s  = redirect_valid && (state_r != IDLE);
  assign handshake_s = instr_valid_r && instr_ready;
  assign capture_s   = (state_r == FETCH) && (!instr_valid_r || instr_ready) && !redirect_s;
  assign at_last_s   = (pc_s == ADDR_W'(LAST_ADDR));

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR),
    .WRAP_EN  (WRAP_EN)
  ) u_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (capture_s),
    .redirect     (redirect_s),
    .redirect_addr(redirect_addr),
    .pc           (pc_s)
  );

  // FSM next state: start leaves IDLE, capturing the last address halts
  // unless wrapping, and redirect always resumes fetching.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        if (redirect_s) begin
          next_state_s = FETCH;
        end else if (capture_s && at_last_s && (WRAP_EN == 0)) begin
          next_state_s = HALTED;
        end else begin
          next_state_s = FETCH;
        end
      end
      HALTED: begin
        if (redirect_s) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = HALTED;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State and halted flag registered together so halted mirrors HALTED exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      halted_r <= (next_state_s == HALTED);
    end
  end

  // Instruction slot: redirect flushes, capture loads, acceptance empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r       <= {DATA_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
    end else if (redirect_s) begin
      instr_valid_r <= 1'b0;
    end else if (capture_s) begin
      instr_r       <= imem_rdata;
      instr_pc_r    <= pc_s;
      instr_valid_r <= 1'b1;
    end else if (handshake_s) begin
      instr_valid_r <= 1'b0;
    end else begin
      instr_valid_r <= instr_valid_r;
    end
  end

  // Saturating count of accepted handshakes, including ones during a redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_r <= {CNT_W{1'b0}};
    end else if (handshake_s && !(&fetch_count_r)) begin
      fetch_count_r <= fetch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign imem_addr   = pc_s;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: three configurations (halt at 63, halt at
// 21, wrap at 63) share stimulus, each checked against a rule-level model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [5:0]  redirect_addr;
  logic        instr_ready;

  logic [31:0] mem [64];

  logic [5:0]  ia   [3];
  logic [31:0] ins  [3];
  logic [5:0]  ipc  [3];
  logic        ivld [3];
  logic        hlt  [3];
  logic [15:0] cnt  [3];

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state, per configuration.
  int          last_a [3] = '{63, 21, 63};
  int          wrap_a [3] = '{0, 0, 1};
  int          m_mode [3];  // 0 idle, 1 fetching, 2 halted
  int          m_pc   [3];
  int          m_vld  [3];
  int          m_ipc  [3];
  int          m_cnt  [3];
  logic [31:0] m_ins  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit #(.LAST_ADDR(63), .WRAP_EN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_addr(ia[0]), .imem_rdata(mem[ia[0]]),
    .instr(ins[0]), .instr_pc(ipc[0]), .instr_valid(ivld[0]), .instr_ready(instr_ready),
    .halted(hlt[0]), .fetch_count(cnt[0]));

  instruction_fetch_unit #(.LAST_ADDR(21), .WRAP_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_addr(ia[1]), .imem_rdata(mem[ia[1]]),
    .instr(ins[1]), .instr_pc(ipc[1]), .instr_valid(ivld[1]), .instr_ready(instr_ready),
    .halted(hlt[1]), .fetch_count(cnt[1]));

  instruction_fetch_unit #(.LAST_ADDR(63), .WRAP_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_addr(ia[2]), .imem_rdata(mem[ia[2]]),
    .instr(ins[2]), .instr_pc(ipc[2]), .instr_valid(ivld[2]), .instr_ready(instr_ready),
    .halted(hlt[2]), .fetch_count(cnt[2]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks_total = checks_total + 1;
    assert (obs === exp) checks_passed = checks_passed + 1;
    else $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, d, obs, exp);
  endtask

  // Advance the model one clock using the inputs about to be sampled.
  task automatic model_step(input bit rn, input bit st, input bit rv, input int ra, input bit rdy);
    for (int d = 0; d < 3; d++) begin
      if (!rn) begin
        m_mode[d] = 0; m_pc[d] = 0; m_vld[d] = 0; m_ipc[d] = 0; m_ins[d] = 32'd0; m_cnt[d] = 0;
      end else begin
        if (m_vld[d] != 0 && rdy && m_cnt[d] < 65535) m_cnt[d] = m_cnt[d] + 1;
        if (m_mode[d] == 0) begin
          if (st) m_mode[d] = 1;
        end else if (rv) begin
          m_pc[d] = ra; m_vld[d] = 0; m_mode[d] = 1;
        end else if (m_mode[d] == 1) begin
          if (m_vld[d] == 0 || rdy) begin
            m_ins[d] = mem[m_pc[d]];
            m_ipc[d] = m_pc[d];
            m_vld[d] = 1;
            if (m_pc[d] == last_a[d]) begin
              if (wrap_a[d] != 0) m_pc[d] = 0;
              else m_mode[d] = 2;
            end else begin
              m_pc[d] = (m_pc[d] + 1) % 64;
            end
          end
        end else begin
          if (m_vld[d] != 0 && rdy) m_vld[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk("instr_valid", d, {31'd0, ivld[d]}, m_vld[d]);
      chk("instr_pc",    d, {26'd0, ipc[d]}, m_ipc[d]);
      chk("instr",       d, ins[d], m_ins[d]);
      chk("halted",      d, {31'd0, hlt[d]}, (m_mode[d] == 2) ? 32'd1 : 32'd0);
      chk("fetch_count", d, {16'd0, cnt[d]}, m_cnt[d]);
      chk("imem_addr",   d, {26'd0, ia[d]}, m_pc[d]);
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit rv, input int ra, input bit rdy);
    rst_n = rn; start = st; redirect_valid = rv; redirect_addr = 6'(ra); instr_ready = rdy;
    model_step(rn, st, rv, ra, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int d = 0; d < 3; d++) begin
      m_mode[d] = 0; m_pc[d] = 0; m_vld[d] = 0; m_ipc[d] = 0; m_ins[d] = 32'd0; m_cnt[d] = 0;
    end
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 6'd0; instr_ready = 1'b0;

    // Reset, then start with ready held high: 0,1,2,... streamed.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    // Stall with instr_pc=5 held for three cycles, then release.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(1, 0, 0, 0, 1);
    // dut_b halted at 21, dut_a halted at 63, dut_c wrapped; redirect all to 2.
    step(1, 0, 1, 2, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    // Redirect to 10 with a pending, unaccepted instruction.
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 10, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    // Redirect to 10 while the pending instruction is accepted.
    step(1, 0, 1, 10, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    // Redirect beyond dut_b's last address, then run through the top.
    step(1, 0, 1, 40, 1);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 1);
    // Start while fetching or halted is ignored; redirect in IDLE is ignored.
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 12, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1);
    // Reset mid-stream, then idle without start.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 11) == 0), int'($urandom_range(0, 63)),
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
